// File: rtl/hilo_unit.sv
// HI/LO register unit: multicycle MULT/MULTU through a combinational multiplier,
// plus MTHI/MTLO writes. Includes the shared Mult multiplier used by the unit.

module Mult (
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    input  logic        i_unsigned,
    output logic [31:0] o_hi,
    output logic [31:0] o_lo
);
    logic signed [32:0] w_a;
    logic signed [32:0] w_b;
    logic signed [65:0] w_prod;

    // A 33-bit extension lets one signed multiply cover both MULT and MULTU.
    assign w_a    = $signed({~i_unsigned & i_a[31], i_a});
    assign w_b    = $signed({~i_unsigned & i_b[31], i_b});
    assign w_prod = w_a * w_b;
    assign o_hi   = w_prod[63:32];
    assign o_lo   = w_prod[31:0];
endmodule

module hilo_unit #(
    parameter int unsigned MULT_LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_start,
    input  logic [31:0] i_opr1,
    input  logic [31:0] i_opr2,
    input  logic        is_unsigned,
    input  logic        i_mthi,
    input  logic        i_mtlo,
    input  logic [31:0] i_wdata,
    output logic        o_busy,
    output logic        o_done,
    output logic [31:0] o_hi,
    output logic [31:0] o_lo
);
    localparam int unsigned DATA_W = 32;
    localparam int unsigned CNT_W  = 4;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [CNT_W-1:0]    r_cnt;
    logic [CNT_W-1:0]    w_cnt_nxt;
    logic                w_load;
    logic                w_capture;
    logic                w_mt_ok;
    logic [DATA_W-1:0]   r_opr1;
    logic [DATA_W-1:0]   r_opr2;
    logic                r_unsigned;
    logic [DATA_W-1:0]   r_hi;
    logic [DATA_W-1:0]   r_lo;
    logic                r_done;
    logic [DATA_W-1:0]   w_mul_hi;
    logic [DATA_W-1:0]   w_mul_lo;

    Mult u_mult (
        .i_a        (r_opr1),
        .i_b        (r_opr2),
        .i_unsigned (r_unsigned),
        .o_hi       (w_mul_hi),
        .o_lo       (w_mul_lo)
    );

    // Next state: capture on the edge where the counter steps from 1 to 0.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_load      = 1'b0;
        w_capture   = 1'b0;
        case (r_state)
            IDLE: begin
                if (i_start) begin
                    w_state_nxt = BUSY;
                    w_cnt_nxt   = CNT_W'(MULT_LATENCY);
                    w_load      = 1'b1;
                end
            end
            BUSY: begin
                w_cnt_nxt = r_cnt - CNT_W'(1);
                if (r_cnt == CNT_W'(1)) begin
                    w_state_nxt = IDLE;
                    w_capture   = 1'b1;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // A start in the same cycle takes precedence over MT writes.
    assign w_mt_ok = (r_state == IDLE) && !i_start;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_opr1     <= '0;
            r_opr2     <= '0;
            r_unsigned <= 1'b0;
            r_hi       <= '0;
            r_lo       <= '0;
            r_done     <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_done  <= w_capture;
            if (w_load) begin
                r_opr1     <= i_opr1;
                r_opr2     <= i_opr2;
                r_unsigned <= is_unsigned;
            end
            if (w_capture) begin
                r_hi <= w_mul_hi;
                r_lo <= w_mul_lo;
            end else if (w_mt_ok) begin
                if (i_mthi) r_hi <= i_wdata;
                if (i_mtlo) r_lo <= i_wdata;
            end
        end
    end

    assign o_busy = (r_state == BUSY);
    assign o_done = r_done;
    assign o_hi   = r_hi;
    assign o_lo   = r_lo;
endmodule

// File: tb/tb_hilo_unit.sv
// Directed bench for hilo_unit with MULT_LATENCY=2; expected values hand-computed.

module tb_hilo_unit;
    logic        clk;
    logic        rst;
    logic        i_start;
    logic [31:0] i_opr1;
    logic [31:0] i_opr2;
    logic        is_unsigned;
    logic        i_mthi;
    logic        i_mtlo;
    logic [31:0] i_wdata;
    logic        o_busy;
    logic        o_done;
    logic [31:0] o_hi;
    logic [31:0] o_lo;

    int errors = 0;
    int checks = 0;

    hilo_unit #(.MULT_LATENCY(2)) dut (
        .clk         (clk),
        .rst         (rst),
        .i_start     (i_start),
        .i_opr1      (i_opr1),
        .i_opr2      (i_opr2),
        .is_unsigned (is_unsigned),
        .i_mthi      (i_mthi),
        .i_mtlo      (i_mtlo),
        .i_wdata     (i_wdata),
        .o_busy      (o_busy),
        .o_done      (o_done),
        .o_hi        (o_hi),
        .o_lo        (o_lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance past the next rising edge; drive and sample 1ns after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a multiply for exactly one edge (edge N), then drop i_start.
    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic u);
        i_start = 1'b1; i_opr1 = a; i_opr2 = b; is_unsigned = u;
        tick();
        i_start = 1'b0; i_opr1 = 32'h0; i_opr2 = 32'h0; is_unsigned = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", o_busy); end
        checks++; if (o_done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", o_done); end
        checks++; if (o_hi !== 32'h0) begin errors++; $display("FAIL reset_hi got=%h exp=0", o_hi); end
        checks++; if (o_lo !== 32'h0) begin errors++; $display("FAIL reset_lo got=%h exp=0", o_lo); end
    endtask

    task automatic test_multu();
        issue(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1);
        checks++; if (o_busy !== 1'b1) begin errors++; $display("FAIL multu_busy_n got=%b exp=1", o_busy); end
        checks++; if (o_hi !== 32'h0) begin errors++; $display("FAIL multu_hi_early got=%h exp=0", o_hi); end
        tick();
        checks++; if (o_busy !== 1'b1) begin errors++; $display("FAIL multu_busy_n1 got=%b exp=1", o_busy); end
        checks++; if (o_done !== 1'b0) begin errors++; $display("FAIL multu_done_n1 got=%b exp=0", o_done); end
        tick();
        checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL multu_busy_n2 got=%b exp=0", o_busy); end
        checks++; if (o_done !== 1'b1) begin errors++; $display("FAIL multu_done_n2 got=%b exp=1", o_done); end
        checks++; if (o_hi !== 32'hFFFFFFFE) begin errors++; $display("FAIL multu_hi got=%h exp=fffffffe", o_hi); end
        checks++; if (o_lo !== 32'h00000001) begin errors++; $display("FAIL multu_lo got=%h exp=00000001", o_lo); end
        tick();
        checks++; if (o_done !== 1'b0) begin errors++; $display("FAIL multu_done_n3 got=%b exp=0", o_done); end
    endtask

    task automatic test_mult_signed();
        issue(32'hFFFFFFFE, 32'h00000003, 1'b0);
        tick(); tick();
        checks++; if (o_hi !== 32'hFFFFFFFF) begin errors++; $display("FAIL mult_neg_hi got=%h exp=ffffffff", o_hi); end
        checks++; if (o_lo !== 32'hFFFFFFFA) begin errors++; $display("FAIL mult_neg_lo got=%h exp=fffffffa", o_lo); end
        issue(32'hFFFFFFFE, 32'h00000003, 1'b1);
        tick(); tick();
        checks++; if (o_hi !== 32'h00000002) begin errors++; $display("FAIL multu_big_hi got=%h exp=00000002", o_hi); end
        checks++; if (o_lo !== 32'hFFFFFFFA) begin errors++; $display("FAIL multu_big_lo got=%h exp=fffffffa", o_lo); end
        issue(32'h80000000, 32'h80000000, 1'b0);
        tick(); tick();
        checks++; if (o_hi !== 32'h40000000) begin errors++; $display("FAIL mult_min_hi got=%h exp=40000000", o_hi); end
        checks++; if (o_lo !== 32'h00000000) begin errors++; $display("FAIL mult_min_lo got=%h exp=00000000", o_lo); end
    endtask

    task automatic test_mt();
        i_mthi = 1'b1; i_wdata = 32'h12345678;
        tick();
        i_mthi = 1'b0;
        checks++; if (o_hi !== 32'h12345678) begin errors++; $display("FAIL mthi_hi got=%h exp=12345678", o_hi); end
        checks++; if (o_lo !== 32'h00000000) begin errors++; $display("FAIL mthi_lo got=%h exp=00000000", o_lo); end
        i_mtlo = 1'b1; i_wdata = 32'h9ABCDEF0;
        tick();
        i_mtlo = 1'b0;
        checks++; if (o_hi !== 32'h12345678) begin errors++; $display("FAIL mtlo_hi got=%h exp=12345678", o_hi); end
        checks++; if (o_lo !== 32'h9ABCDEF0) begin errors++; $display("FAIL mtlo_lo got=%h exp=9abcdef0", o_lo); end
        i_mthi = 1'b1; i_mtlo = 1'b1; i_wdata = 32'h0000000F;
        tick();
        i_mthi = 1'b0; i_mtlo = 1'b0;
        checks++; if (o_hi !== 32'h0000000F) begin errors++; $display("FAIL mtboth_hi got=%h exp=0000000f", o_hi); end
        checks++; if (o_lo !== 32'h0000000F) begin errors++; $display("FAIL mtboth_lo got=%h exp=0000000f", o_lo); end
        checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL mt_busy got=%b exp=0", o_busy); end
    endtask

    task automatic test_busy_ignore();
        issue(32'h00010000, 32'h00010000, 1'b1);
        i_start = 1'b1; i_opr1 = 32'h3; i_opr2 = 32'h5; is_unsigned = 1'b1;
        i_mthi = 1'b1; i_wdata = 32'hDEADBEEF;
        tick();
        i_start = 1'b0; i_mthi = 1'b0; i_opr1 = 32'h0; i_opr2 = 32'h0;
        checks++; if (o_hi !== 32'h0000000F) begin errors++; $display("FAIL busy_mthi_hi got=%h exp=0000000f", o_hi); end
        checks++; if (o_busy !== 1'b1) begin errors++; $display("FAIL busy_ign_busy got=%b exp=1", o_busy); end
        tick();
        checks++; if (o_done !== 1'b1) begin errors++; $display("FAIL busy_ign_done got=%b exp=1", o_done); end
        checks++; if (o_hi !== 32'h00000001) begin errors++; $display("FAIL busy_ign_hi got=%h exp=00000001", o_hi); end
        checks++; if (o_lo !== 32'h00000000) begin errors++; $display("FAIL busy_ign_lo got=%h exp=00000000", o_lo); end
        tick();
        checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL busy_ign_queued got=%b exp=0", o_busy); end
        tick(); tick();
        checks++; if (o_done !== 1'b0) begin errors++; $display("FAIL busy_ign_late_done got=%b exp=0", o_done); end
        checks++; if (o_hi !== 32'h00000001) begin errors++; $display("FAIL busy_ign_late_hi got=%h exp=00000001", o_hi); end
    endtask

    task automatic test_back_to_back();
        issue(32'h00000006, 32'h00000007, 1'b0);
        tick(); tick();
        checks++; if (o_done !== 1'b1) begin errors++; $display("FAIL b2b_done1 got=%b exp=1", o_done); end
        checks++; if (o_lo !== 32'd42) begin errors++; $display("FAIL b2b_lo1 got=%h exp=0000002a", o_lo); end
        issue(32'hFFFFFFFF, 32'h00000002, 1'b0);
        checks++; if (o_busy !== 1'b1) begin errors++; $display("FAIL b2b_busy got=%b exp=1", o_busy); end
        checks++; if (o_done !== 1'b0) begin errors++; $display("FAIL b2b_done_gap got=%b exp=0", o_done); end
        tick(); tick();
        checks++; if (o_done !== 1'b1) begin errors++; $display("FAIL b2b_done2 got=%b exp=1", o_done); end
        checks++; if (o_hi !== 32'hFFFFFFFF) begin errors++; $display("FAIL b2b_hi2 got=%h exp=ffffffff", o_hi); end
        checks++; if (o_lo !== 32'hFFFFFFFE) begin errors++; $display("FAIL b2b_lo2 got=%h exp=fffffffe", o_lo); end
    endtask

    task automatic test_reset_busy();
        issue(32'h00000005, 32'h00000005, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL rstb_busy got=%b exp=0", o_busy); end
        checks++; if (o_hi !== 32'h0) begin errors++; $display("FAIL rstb_hi got=%h exp=0", o_hi); end
        checks++; if (o_lo !== 32'h0) begin errors++; $display("FAIL rstb_lo got=%h exp=0", o_lo); end
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++; if (o_done !== 1'b0 || o_lo !== 32'h0) begin
                errors++; $display("FAIL rstb_quiet[%0d] done=%b lo=%h exp done=0 lo=0", i, o_done, o_lo);
            end
        end
        // Reset beats start and MT writes presented on the same edge.
        i_mthi = 1'b1; i_wdata = 32'h55AA55AA;
        i_start = 1'b1; i_opr1 = 32'h2; i_opr2 = 32'h2; rst = 1'b1;
        tick();
        rst = 1'b0; i_start = 1'b0; i_mthi = 1'b0;
        checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL rstpri_busy got=%b exp=0", o_busy); end
        checks++; if (o_hi !== 32'h0) begin errors++; $display("FAIL rstpri_hi got=%h exp=0", o_hi); end
    endtask

    task automatic test_start_mtlo();
        i_start = 1'b1; i_opr1 = 32'h3; i_opr2 = 32'h4; is_unsigned = 1'b0;
        i_mtlo = 1'b1; i_wdata = 32'hCAFEBABE;
        tick();
        i_start = 1'b0; i_mtlo = 1'b0;
        checks++; if (o_lo !== 32'h0) begin errors++; $display("FAIL smt_lo_n got=%h exp=0", o_lo); end
        checks++; if (o_busy !== 1'b1) begin errors++; $display("FAIL smt_busy got=%b exp=1", o_busy); end
        tick(); tick();
        checks++; if (o_done !== 1'b1) begin errors++; $display("FAIL smt_done got=%b exp=1", o_done); end
        checks++; if (o_lo !== 32'd12) begin errors++; $display("FAIL smt_lo got=%h exp=0000000c", o_lo); end
        checks++; if (o_hi !== 32'h0) begin errors++; $display("FAIL smt_hi got=%h exp=0", o_hi); end
    endtask

    initial begin
        rst = 1'b1; i_start = 1'b0; i_opr1 = 32'h0; i_opr2 = 32'h0; is_unsigned = 1'b0;
        i_mthi = 1'b0; i_mtlo = 1'b0; i_wdata = 32'h0;
        test_reset();
        test_multu();
        test_mult_signed();
        test_mt();
        test_busy_ignore();
        test_back_to_back();
        test_reset_busy();
        test_start_mtlo();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/hilo_unit.md
HILO_UNIT -- requirements
Module: hilo_unit

Interface
REQ-001 SHALL provide parameter MULT_LATENCY, default 2, legal range 1..15: the number of clock cycles allowed for the combinational multiplier path before its result is captured.
REQ-002 SHALL provide port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL provide port rst  input  1  synchronous active-high reset.
REQ-004 SHALL provide port i_start  input  1  issue a multiply (MULT/MULTU) this cycle.
REQ-005 SHALL provide port i_opr1  input  32  multiplicand, sampled with i_start.
REQ-006 SHALL provide port i_opr2  input  32  multiplier, sampled with i_start.
REQ-007 SHALL provide port is_unsigned  input  1  1 = MULTU, 0 = MULT; sampled with i_start.
REQ-008 SHALL provide port i_mthi  input  1  write i_wdata to HI.
REQ-009 SHALL provide port i_mtlo  input  1  write i_wdata to LO.
REQ-010 SHALL provide port i_wdata  input  32  MTHI/MTLO data.
REQ-011 SHALL provide port o_busy  output  1  multiply in flight.
REQ-012 SHALL provide port o_done  output  1  one-cycle pulse: HI/LO just updated by a multiply.
REQ-013 SHALL provide port o_hi  output  32  HI register contents.
REQ-014 SHALL provide port o_lo  output  32  LO register contents.

Function
REQ-015 SHALL instantiate the team's combinational 32x32 signed/unsigned multiplier Mult and feed it only from internal operand registers, never from input ports.
REQ-016 SHALL implement a two-state FSM: IDLE, BUSY.
REQ-017 In IDLE, i_start=1 at edge N SHALL latch i_opr1, i_opr2 and is_unsigned, load the cycle counter with MULT_LATENCY, and enter BUSY.
REQ-018 In BUSY, the counter SHALL decrement once per edge; at the edge where it reaches 0 (edge N+MULT_LATENCY), the unit SHALL write the multiplier's hi/lo into HI/LO and return to IDLE.
REQ-019 o_busy SHALL equal (state==BUSY), i.e. high for exactly MULT_LATENCY cycles per multiply.
REQ-020 o_done SHALL be registered and high for exactly the one cycle following the HI/LO capture edge.
REQ-021 i_start while BUSY SHALL be ignored: no queuing, operand registers unchanged.
REQ-022 i_mthi/i_mtlo in IDLE with i_start=0 SHALL write i_wdata into HI/LO at the next edge; if both are asserted, both registers SHALL receive i_wdata.
REQ-023 i_mthi/i_mtlo while BUSY SHALL be ignored; the caller stalls on o_busy.
REQ-024 When i_start and i_mthi/i_mtlo are asserted together in IDLE, i_start SHALL win and the MT writes SHALL be dropped.
REQ-025 HI/LO SHALL change only on a multiply capture, an accepted MT write, or reset; o_hi/o_lo SHALL drive the registers directly, with no bypass.
REQ-026 The product SHALL be the full 64-bit two's-complement (MULT) or unsigned (MULTU) result: HI = bits 63:32, LO = bits 31:0.
REQ-027 Back-to-back operation SHALL be supported: a start sampled in the o_done cycle is accepted.

Reset
REQ-028 rst=1 at any edge SHALL force state IDLE, counter 0, operand registers 0, HI=0, LO=0, o_busy=0, o_done=0.
REQ-029 Reset during BUSY SHALL discard the in-flight multiply: no later HI/LO write and no o_done pulse.
REQ-030 rst SHALL have priority over i_start, i_mthi and i_mtlo in the same cycle.

Verification
REQ-031 MULTU 0xFFFFFFFF*0xFFFFFFFF, MULT_LATENCY=2 -> o_busy high for 2 cycles; HI=0xFFFFFFFE, LO=0x00000001 at edge N+2; o_done high for the next cycle.
REQ-032 MULT 0xFFFFFFFE*0x00000003 -> HI=0xFFFFFFFF, LO=0xFFFFFFFA; MULT 0x80000000*0x80000000 -> HI=0x40000000, LO=0x00000000.
REQ-033 MTHI 0x12345678, then MTLO 0x9ABCDEF0 -> o_hi=0x12345678, o_lo=0x9ABCDEF0; then both in one cycle with 0x0000000F -> both 0x0000000F.
REQ-034 While BUSY, pulse i_start with new operands and i_mthi with 0xDEADBEEF -> both ignored; the first product is captured unchanged.
REQ-035 Assert rst one cycle after i_start -> HI=LO=0, o_busy=0, and no o_done for the following 2*MULT_LATENCY cycles.
REQ-036 i_start and i_mtlo together in IDLE -> product captured; LO never holds i_wdata.
